// File: rtl/hwpe_buffer_rr_arbiter.sv
// hwpe_buffer_rr_arbiter
//   Funnels NB_REQ valid/ready producer streams into one registered buffer
//   slot using round-robin arbitration. The slot drains through a single
//   valid/ready output with 1-cycle latency and full throughput.
//   Optional per-requester saturating grant counters are built when the
//   macro HWPE_BUFFER_ARB_STATS_EN is defined; otherwise grant_cnt_o is 0.
module hwpe_buffer_rr_arbiter #(
  parameter int unsigned BUFFER_WIDTH = 32,
  parameter int unsigned NB_REQ       = 4,
  parameter int unsigned CNT_WIDTH    = 16,
  localparam int unsigned SRC_W       = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NB_REQ-1:0]              req_valid_i,
  output logic [NB_REQ-1:0]              req_ready_o,
  input  logic [NB_REQ*BUFFER_WIDTH-1:0] req_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [BUFFER_WIDTH-1:0]        out_data_o,
  output logic [SRC_W-1:0]               out_src_o,
  output logic [NB_REQ*CNT_WIDTH-1:0]    grant_cnt_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e state_q, state_d;

  logic [SRC_W-1:0]        ptr_q, ptr_d;
  logic [SRC_W-1:0]        winner;
  logic                    found;
  logic                    can_accept;
  logic                    accept;
  logic [BUFFER_WIDTH-1:0] data_q;
  logic [SRC_W-1:0]        src_q;
  logic [BUFFER_WIDTH-1:0] req_data [NB_REQ];

  // Unpack the flat requester data bus into one word per requester.
  for (genvar r = 0; r < NB_REQ; r++) begin : g_unpack
    assign req_data[r] = req_data_i[r*BUFFER_WIDTH +: BUFFER_WIDTH];
  end

  // The slot can take a new word when empty or when it is draining this cycle;
  // nothing is granted while reset is asserted.
  assign can_accept = rst_ni & ((state_q == EMPTY) | out_ready_i);
  assign accept     = found & can_accept;

  // Round-robin search: first valid requester starting at ptr_q, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(NB_REQ); i++) begin
      int unsigned idx;
      logic [SRC_W-1:0] cand;
      idx  = (int'(ptr_q) + i) % NB_REQ;
      cand = SRC_W'(idx);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // One-hot ready to the winner only, and only when the slot can take data.
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o = NB_REQ'(1) << winner;
    end
  end

  // Pointer moves just past the accepted requester; holds otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (winner == SRC_W'(NB_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = winner + SRC_W'(1);
      end
    end
  end

  // Slot state transitions: fill on accept, empty on drain without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (out_ready_i && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Slot payload: loaded on accept, held through drains and stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      src_q  <= '0;
    end else if (accept) begin
      data_q <= req_data[winner];
      src_q  <= winner;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;
  assign out_src_o   = src_q;

`ifdef HWPE_BUFFER_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NB_REQ];

  // Per-requester accepted-transfer counters, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < int'(NB_REQ); r++) cnt_q[r] <= '0;
    end else if (accept && (cnt_q[winner] != '1)) begin
      cnt_q[winner] <= cnt_q[winner] + CNT_WIDTH'(1);
    end
  end

  for (genvar r = 0; r < NB_REQ; r++) begin : g_cnt_out
    assign grant_cnt_o[r*CNT_WIDTH +: CNT_WIDTH] = cnt_q[r];
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_buffer_rr_arbiter.sv
// Directed bench for hwpe_buffer_rr_arbiter (N=4, W=32, CNT_WIDTH=2).
// Stimulus pushes expected output words into a scoreboard; a negedge monitor
// pops and compares on every output handshake.
module tb_hwpe_buffer_rr_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_ready_o;
  logic [N*W-1:0]   req_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [W-1:0]     out_data_o;
  logic [1:0]       out_src_o;
  logic [N*CW-1:0]  grant_cnt_o;

  hwpe_buffer_rr_arbiter #(
    .BUFFER_WIDTH(W),
    .NB_REQ      (N),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_data_i (req_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_src_o  (out_src_o),
    .grant_cnt_o(grant_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   src;
  } exp_t;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb_q[$];
  int   model_cnt[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] tag(input int r, input int seq);
    return {8'hD0, 8'(r), 16'(seq)};
  endfunction

  task automatic set_data(input int seq);
    for (int r = 0; r < N; r++) req_data_i[r*W +: W] = tag(r, seq);
  endtask

  task automatic push_exp(input logic [W-1:0] data, input int r);
    sb_q.push_back({data, 2'(r)});
    if (model_cnt[r] < 3) model_cnt[r]++;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_counters(input string name);
    for (int r = 0; r < N; r++) begin
      int exp_c;
`ifdef HWPE_BUFFER_ARB_STATS_EN
      exp_c = model_cnt[r];
`else
      exp_c = 0;
`endif
      check($sformatf("%s_cnt%0d", name, r), 64'(grant_cnt_o[r*CW +: CW]), 64'(exp_c));
    end
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got data 0x%0h src %0d with no expected entry", out_data_o, out_src_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_data", 64'(out_data_o), 64'(e.data));
        check("out_src",  64'(out_src_o),  64'(e.src));
      end
    end
  end

  int rr_order[8] = '{2, 3, 0, 1, 2, 3, 0, 1};

  initial begin
    for (int r = 0; r < N; r++) model_cnt[r] = 0;
    rst_ni      = 1'b0;
    req_valid_i = '1;
    out_ready_i = 1'b1;
    set_data(0);

    // Reset held with all requesters valid.
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'd0);
    check("rst_data",  64'(out_data_o),  64'd0);
    check("rst_src",   64'(out_src_o),   64'd0);
    check("rst_cnt",   64'(grant_cnt_o), 64'd0);
    req_valid_i = '0;
    rst_ni      = 1'b1;
    next_cycle();

    // Single requester 2, ptr 0.
    req_valid_i = 4'b0100;
    set_data(1);
    req_data_i[2*W +: W] = 32'hA5A5_0001;
    #1;
    check("single_ready", 64'(req_ready_o), 64'b0100);
    push_exp(32'hA5A5_0001, 2);
    next_cycle();
    check("single_valid", 64'(out_valid_o), 64'd1);
    check("single_data",  64'(out_data_o),  64'hA5A5_0001);
    check("single_src",   64'(out_src_o),   64'd2);

    // ptr is now 3; only req 1 valid -> wrap and skip to 1, ptr becomes 2.
    req_valid_i = 4'b0010;
    set_data(2);
    #1;
    check("wrap_ready", 64'(req_ready_o), 64'b0010);
    push_exp(tag(1, 2), 1);
    next_cycle();

    // All valid: grants rotate starting at 2, one per cycle.
    req_valid_i = '1;
    for (int i = 0; i < 8; i++) begin
      set_data(10 + i);
      #1;
      check($sformatf("rr_ready%0d", i), 64'(req_ready_o), 64'(4'b0001 << rr_order[i]));
      push_exp(tag(rr_order[i], 10 + i), rr_order[i]);
      next_cycle();
      check($sformatf("rr_valid%0d", i), 64'(out_valid_o), 64'd1);
    end

    // Backpressure: slot holds req 1 / seq 17, stalls for 5 cycles.
    out_ready_i = 1'b0;
    set_data(30);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_ready%0d", i), 64'(req_ready_o), 64'd0);
      check($sformatf("stall_valid%0d", i), 64'(out_valid_o), 64'd1);
      check($sformatf("stall_data%0d", i),  64'(out_data_o),  64'(tag(1, 17)));
      check($sformatf("stall_src%0d", i),   64'(out_src_o),   64'd1);
      next_cycle();
    end

    // Release: drain and refill in the same cycle (ptr 2 -> grant 2).
    out_ready_i = 1'b1;
    set_data(40);
    #1;
    check("release_ready", 64'(req_ready_o), 64'b0100);
    push_exp(tag(2, 40), 2);
    next_cycle();
    check("release_valid", 64'(out_valid_o), 64'd1);
    check("release_data",  64'(out_data_o),  64'(tag(2, 40)));

    // Drain only: valid drops, data and src hold.
    req_valid_i = '0;
    #1;
    check("drain_ready", 64'(req_ready_o), 64'd0);
    next_cycle();
    check("drain_valid", 64'(out_valid_o), 64'd0);
    check("drain_data",  64'(out_data_o),  64'(tag(2, 40)));
    check("drain_src",   64'(out_src_o),   64'd2);
    check_counters("pre_rst");

    // Reset while FULL: ptr is 3, only req 0 valid.
    out_ready_i = 1'b0;
    req_valid_i = 4'b0001;
    set_data(50);
    #1;
    check("midfull_ready", 64'(req_ready_o), 64'b0001);
    next_cycle();
    check("midfull_valid", 64'(out_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid_o), 64'd0);
    check("midrst_ready", 64'(req_ready_o), 64'd0);
    check("midrst_cnt",   64'(grant_cnt_o), 64'd0);
    for (int r = 0; r < N; r++) model_cnt[r] = 0;
    req_valid_i = '0;
    next_cycle();
    rst_ni = 1'b1;
    out_ready_i = 1'b1;

    // After reset ptr is 0: all valid -> req 0 wins.
    req_valid_i = '1;
    #1;
    check("post_rst_ready", 64'(req_ready_o), 64'b0001);

    // Five accepts from req 0: counter saturates at 3 when stats are built.
    req_valid_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      set_data(60 + i);
      #1;
      check($sformatf("stats_ready%0d", i), 64'(req_ready_o), 64'b0001);
      push_exp(tag(0, 60 + i), 0);
      next_cycle();
    end
    req_valid_i = '0;
    next_cycle();
    check_counters("stats");
`ifdef HWPE_BUFFER_ARB_STATS_EN
    check("stats_sat0", 64'(grant_cnt_o[CW-1:0]), 64'd3);
`else
    check("stats_off", 64'(grant_cnt_o), 64'd0);
`endif

    // Bounded wait for the scoreboard to empty.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) next_cycle();
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_drain: %0d expected words never appeared", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
